pc_nzp_unit: RTL and testbench

- Per-thread program-counter and condition unit. It is the consumer of the ALU result/NZP output inside each thread lane of a compute core.
- Latches NZP flags from the ALU's compare output during UPDATE.
- Computes the next PC during EXECUTE: sequential, conditional branch (BRnzp) or call/return.
- Driven by the same core_state sequencer as the ALU; next_pc is returned to the core's fetch logic.

---
 rtl/gpu_pkg.sv | 22 ++
 rtl/ret_stack.sv | 42 ++++
 rtl/pc_nzp_unit.sv | 121 ++++++++++++
 tb/tb_pc_nzp_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared core definitions: sequencer state encoding, NZP bit positions, default widths.
package gpu_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      FETCH   = 3'b001,
      DECODE  = 3'b010,
      REQUEST = 3'b011,
      WAIT    = 3'b100,
      EXECUTE = 3'b101,
      UPDATE  = 3'b110,
      DONE    = 3'b111
   } core_state_t;

   localparam int unsigned NZP_N = 2;
   localparam int unsigned NZP_Z = 1;
   localparam int unsigned NZP_P = 0;

   localparam int unsigned PC_W_DEF   = 8;
   localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO used by CALL/RET; only built when PC_CALL_STACK_EN is defined.
`ifdef PC_CALL_STACK_EN
module ret_stack #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top_c,
   output logic         full_c,
   output logic         empty_c
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] sp;
   logic [IDX_W-1:0] top_idx;

   assign full_c  = (sp == PTR_W'(DEPTH));
   assign empty_c = (sp == '0);
   assign top_idx = IDX_W'(sp - PTR_W'(1));
   assign top_c   = mem[top_idx];

   // Pop has priority; a push into a full stack is silently dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sp <= '0;
      end else if (pop && !empty_c) begin
         sp <= sp - PTR_W'(1);
      end else if (push && !full_c) begin
         mem[sp[IDX_W-1:0]] <= push_data;
         sp                 <= sp + PTR_W'(1);
      end
   end

endmodule
`endif

// File: rtl/pc_nzp_unit.sv
// Per-lane PC and NZP condition unit: latches CMP flags in UPDATE, resolves next PC in EXECUTE.
// Optional CALL/RET return stack enabled by defining PC_CALL_STACK_EN.
module pc_nzp_unit
   import gpu_pkg::*;
#(
   parameter int unsigned PC_W        = PC_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [2:0]        core_state,
   input  logic [PC_W-1:0]   current_pc,
   input  logic              decoded_pc_mux,
   input  logic [2:0]        decoded_nzp,
   input  logic [PC_W-1:0]   decoded_imm,
   input  logic              decoded_nzp_write_en,
   input  logic              decoded_call,
   input  logic              decoded_ret,
   input  logic [DATA_W-1:0] alu_out,
   output logic [PC_W-1:0]   next_pc,
   output logic [2:0]        nzp,
   output logic              branch_taken,
   output logic              stack_err
);

   core_state_t     state;
   logic            exec_c;
   logic            upd_c;
   logic            br_hit_c;
   logic [PC_W-1:0] seq_pc_c;
   logic [PC_W-1:0] pc_d;
   logic [2:0]      nzp_d;
   logic            bt_d;
   logic            err_d;
   logic            unused_alu;

   assign state      = core_state_t'(core_state);
   assign exec_c     = enable && (state == EXECUTE);
   assign upd_c      = enable && (state == UPDATE);
   assign seq_pc_c   = current_pc + PC_W'(1);
   assign br_hit_c   = decoded_pc_mux && ((nzp & decoded_nzp) != 3'b000);
   assign unused_alu = ^alu_out[DATA_W-1:3];

`ifdef PC_CALL_STACK_EN
   logic            push_c;
   logic            pop_c;
   logic            full_c;
   logic            empty_c;
   logic [PC_W-1:0] top_c;

   ret_stack #(.W(PC_W), .DEPTH(STACK_DEPTH)) u_ret_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (push_c),
      .pop       (pop_c),
      .push_data (seq_pc_c),
      .top_c     (top_c),
      .full_c    (full_c),
      .empty_c   (empty_c)
   );
`else
   logic unused_stack;
   assign unused_stack = ^{decoded_call, decoded_ret, 32'(STACK_DEPTH)};
`endif

   // Next-state selection: ret > call > branch > sequential, flags only in UPDATE.
   always_comb begin
      pc_d  = next_pc;
      bt_d  = branch_taken;
      nzp_d = nzp;
      err_d = stack_err;
`ifdef PC_CALL_STACK_EN
      push_c = 1'b0;
      pop_c  = 1'b0;
`endif
      if (exec_c) begin
         pc_d = seq_pc_c;
         bt_d = 1'b0;
`ifdef PC_CALL_STACK_EN
         if (decoded_ret) begin
            if (empty_c) begin
               err_d = 1'b1;
            end else begin
               pop_c = 1'b1;
               pc_d  = top_c;
               bt_d  = 1'b1;
            end
         end else if (decoded_call) begin
            pc_d = decoded_imm;
            bt_d = 1'b1;
            if (full_c) err_d = 1'b1;
            else        push_c = 1'b1;
         end else
`endif
         if (br_hit_c) begin
            pc_d = decoded_imm;
            bt_d = 1'b1;
         end
      end
      if (upd_c && decoded_nzp_write_en) begin
         nzp_d = {alu_out[NZP_N], alu_out[NZP_Z], alu_out[NZP_P]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         next_pc      <= '0;
         nzp          <= 3'b000;
         branch_taken <= 1'b0;
         stack_err    <= 1'b0;
      end else begin
         next_pc      <= pc_d;
         nzp          <= nzp_d;
         branch_taken <= bt_d;
         stack_err    <= err_d;
      end
   end

endmodule

// File: tb/tb_pc_nzp_unit.sv
// Randomized self-checking bench for pc_nzp_unit against a queue-based reference model.
module tb_pc_nzp_unit;

   localparam int unsigned PC_W   = 8;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic [2:0]        core_state;
   logic [PC_W-1:0]   current_pc;
   logic              decoded_pc_mux;
   logic [2:0]        decoded_nzp;
   logic [PC_W-1:0]   decoded_imm;
   logic              decoded_nzp_write_en;
   logic              decoded_call;
   logic              decoded_ret;
   logic [DATA_W-1:0] alu_out;
   logic [PC_W-1:0]   next_pc;
   logic [2:0]        nzp;
   logic              branch_taken;
   logic              stack_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [PC_W-1:0] m_pc;
   logic [2:0]      m_nzp;
   logic            m_bt;
   logic            m_err;
   logic [PC_W-1:0] m_stk[$];

   always #5 clk = ~clk;

   pc_nzp_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .STACK_DEPTH(DEPTH)) dut (
      .clk                  (clk),
      .reset                (reset),
      .enable               (enable),
      .core_state           (core_state),
      .current_pc           (current_pc),
      .decoded_pc_mux       (decoded_pc_mux),
      .decoded_nzp          (decoded_nzp),
      .decoded_imm          (decoded_imm),
      .decoded_nzp_write_en (decoded_nzp_write_en),
      .decoded_call         (decoded_call),
      .decoded_ret          (decoded_ret),
      .alu_out              (alu_out),
      .next_pc              (next_pc),
      .nzp                  (nzp),
      .branch_taken         (branch_taken),
      .stack_err            (stack_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Architectural behaviour at one clock edge, from the current inputs.
   task automatic model_step();
      logic [PC_W-1:0] seq;
      seq = current_pc + 8'd1;
      if (!reset) begin
         m_pc = '0; m_nzp = '0; m_bt = 1'b0; m_err = 1'b0;
         m_stk.delete();
      end else if (enable) begin
         if (core_state == 3'd5) begin
            m_pc = seq;
            m_bt = 1'b0;
`ifdef PC_CALL_STACK_EN
            if (decoded_ret) begin
               if (m_stk.size() == 0) m_err = 1'b1;
               else begin m_pc = m_stk.pop_back(); m_bt = 1'b1; end
            end else if (decoded_call) begin
               m_pc = decoded_imm;
               m_bt = 1'b1;
               if (m_stk.size() == DEPTH) m_err = 1'b1;
               else m_stk.push_back(seq);
            end else
`endif
            if (decoded_pc_mux && ((m_nzp & decoded_nzp) != 0)) begin
               m_pc = decoded_imm;
               m_bt = 1'b1;
            end
         end else if (core_state == 3'd6 && decoded_nzp_write_en) begin
            m_nzp = alu_out[2:0];
         end
      end
   endtask

   task automatic cyc(input string tag, input logic [2:0] st, input logic en, input logic rst,
                      input logic [7:0] pc, input logic mux, input logic [2:0] mask,
                      input logic [7:0] imm, input logic we, input logic call, input logic ret,
                      input logic [7:0] alu);
      core_state = st; enable = en; reset = rst; current_pc = pc;
      decoded_pc_mux = mux; decoded_nzp = mask; decoded_imm = imm;
      decoded_nzp_write_en = we; decoded_call = call; decoded_ret = ret; alu_out = alu;
      @(posedge clk);
      model_step();
      #1;
      check({tag, ".next_pc"}, 32'(next_pc), 32'(m_pc));
      check({tag, ".nzp"}, 32'(nzp), 32'(m_nzp));
      check({tag, ".branch_taken"}, 32'(branch_taken), 32'(m_bt));
      check({tag, ".stack_err"}, 32'(stack_err), 32'(m_err));
   endtask

   initial begin
      m_pc = '0; m_nzp = '0; m_bt = 1'b0; m_err = 1'b0;

      cyc("reset", 3'd0, 1, 0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 8'h00);
      check("reset_pc_k", 32'(next_pc), 32'h0);

      cyc("seq05", 3'd5, 1, 1, 8'h05, 0, 3'd0, 8'h00, 0, 0, 0, 8'h00);
      check("seq05_k", 32'(next_pc), 32'h06);
      cyc("seqFF", 3'd5, 1, 1, 8'hFF, 0, 3'd0, 8'h00, 0, 0, 0, 8'h00);
      check("seqFF_wrap_k", 32'(next_pc), 32'h00);

      cyc("br_nzp0", 3'd5, 1, 1, 8'h10, 1, 3'b111, 8'h20, 0, 0, 0, 8'h00);
      check("br_nzp0_k", 32'(next_pc), 32'h11);

      cyc("cmp_z", 3'd6, 1, 1, 8'h10, 0, 3'd0, 8'h00, 1, 0, 0, 8'h02);
      check("cmp_z_k", 32'(nzp), 32'h2);
      cyc("brz", 3'd5, 1, 1, 8'h11, 1, 3'b010, 8'h40, 0, 0, 0, 8'h00);
      check("brz_k", 32'(next_pc), 32'h40);
      check("brz_bt_k", 32'(branch_taken), 32'h1);
      cyc("upd_hold", 3'd6, 1, 1, 8'h11, 0, 3'd0, 8'h00, 0, 0, 0, 8'h00);
      cyc("br101", 3'd5, 1, 1, 8'h30, 1, 3'b101, 8'h40, 0, 0, 0, 8'h00);
      check("br101_k", 32'(next_pc), 32'h31);

      cyc("en0_exec", 3'd5, 0, 1, 8'h77, 1, 3'b111, 8'h99, 0, 0, 0, 8'h00);
      cyc("en0_upd", 3'd6, 0, 1, 8'h77, 0, 3'd0, 8'h00, 1, 0, 0, 8'h05);
      cyc("other_st", 3'd3, 1, 1, 8'h55, 1, 3'b111, 8'h99, 1, 0, 0, 8'h05);
      cyc("cmp_big", 3'd6, 1, 1, 8'h00, 0, 3'd0, 8'h00, 1, 0, 0, 8'hFF);
      check("cmp_big_k", 32'(nzp), 32'h7);
      cyc("br_take", 3'd5, 1, 1, 8'h01, 1, 3'b001, 8'hA0, 0, 0, 0, 8'h00);
      cyc("rst_exec", 3'd5, 1, 0, 8'h02, 1, 3'b111, 8'hB0, 0, 0, 0, 8'h00);
      check("rst_exec_k", 32'({next_pc, nzp, branch_taken, stack_err}), 32'h0);

`ifdef PC_CALL_STACK_EN
      for (int i = 0; i < 4; i++)
         cyc("call", 3'd5, 1, 1, 8'(8'h10 + i), 0, 3'd0, 8'h50, 0, 1, 0, 8'h00);
      cyc("call_full", 3'd5, 1, 1, 8'h14, 0, 3'd0, 8'h50, 0, 1, 0, 8'h00);
      check("call_full_err_k", 32'(stack_err), 32'h1);
      check("call_full_pc_k", 32'(next_pc), 32'h50);
      for (int i = 0; i < 4; i++) begin
         cyc("ret", 3'd5, 1, 1, 8'h60, 0, 3'd0, 8'h00, 0, 0, 1, 8'h00);
         check("ret_k", 32'(next_pc), 32'(8'h14 - i));
      end
      cyc("ret_empty", 3'd5, 1, 1, 8'h60, 0, 3'd0, 8'h00, 0, 0, 1, 8'h00);
      check("ret_empty_k", 32'(next_pc), 32'h61);
      check("ret_empty_err_k", 32'(stack_err), 32'h1);
      cyc("reset2", 3'd0, 1, 0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 8'h00);
`else
      cyc("callret_off", 3'd5, 1, 1, 8'h20, 0, 3'd0, 8'h50, 0, 1, 1, 8'h00);
      check("callret_off_k", 32'(next_pc), 32'h21);
      cyc("call_off", 3'd5, 1, 1, 8'h21, 0, 3'd0, 8'h50, 0, 1, 0, 8'h00);
      check("call_off_k", 32'(next_pc), 32'h22);
`endif

      for (int i = 0; i < 400; i++) begin
         logic [2:0] st;
         st = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                          : (($urandom_range(0, 1) == 0) ? 3'd5 : 3'd6);
         cyc("rand", st, ($urandom_range(0, 9) != 0), ($urandom_range(0, 39) != 0),
             8'($urandom), 1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
